pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_slot.sv | 33 +++
 rtl/pipe_skid_reg.sv | 143 ++++++++++++++
 tb/tb_pipe_skid_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register: bubble instruction,
// occupancy state encoding and the state-to-count mapping.
package pipe_pkg;

    // addi x0, x0, 0: the canonical RISC-V no-op presented during bubbles
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // Number of held entries for a given occupancy state
    function automatic logic [1:0] state_count(input pipe_state_e s);
        case (s)
            EMPTY:   return 2'd0;
            HALF:    return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the skid register: load-enable register holding an
// instruction, its control bits and its payload. Asynchronous clear returns
// the slot to a no-op with zero control and zero payload.
module pipe_slot #(
    parameter int          DATA_W    = 32,
    parameter int          CTRL_W    = 8,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [31:0]       i_instr,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic [31:0]       o_instr,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    // Capture the incoming entry when loaded, otherwise hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_instr <= NOP_INSTR;
            o_ctrl  <= '0;
            o_data  <= '0;
        end else if (i_load) begin
            o_instr <= i_instr;
            o_ctrl  <= i_ctrl;
            o_data  <= i_data;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages. OUT drives the downstream
// side directly; SKID catches the one entry that can arrive while the
// downstream stalls, which lets o_ready be a plain register with no
// combinational path from i_ready.
module pipe_skid_reg #(
    parameter int          DATA_W    = 32,
    parameter int          CTRL_W    = 8,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_instr,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_instr,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    import pipe_pkg::pipe_state_e;
    import pipe_pkg::EMPTY;
    import pipe_pkg::HALF;
    import pipe_pkg::FULL;
    import pipe_pkg::state_count;

    pipe_state_e       state_reg, state_next;
    logic              ready_reg;
    logic              accept, drain;
    logic              out_load, skid_load, out_from_skid;

    logic [31:0]       out_instr, skid_instr, out_instr_in;
    logic [CTRL_W-1:0] out_ctrl, skid_ctrl, out_ctrl_in;
    logic [DATA_W-1:0] out_data, skid_data, out_data_in;

    assign accept = i_valid & ready_reg;
    assign drain  = (state_reg != EMPTY) & i_ready;

    // Occupancy state and the registered ready that follows the next state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= EMPTY;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next != FULL);
        end
    end

    // Next-state decode and slot load selection; flush overrides everything
    always_comb begin
        state_next    = state_reg;
        out_load      = 1'b0;
        skid_load     = 1'b0;
        out_from_skid = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next = HALF;
                    out_load   = 1'b1;
                end
            end
            HALF: begin
                if (accept && drain) begin
                    out_load = 1'b1;
                end else if (accept) begin
                    state_next = FULL;
                    skid_load  = 1'b1;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_next    = HALF;
                    out_load      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (i_flush) begin
            state_next = EMPTY;
            out_load   = 1'b0;
            skid_load  = 1'b0;
        end
    end

    // OUT is refilled either from upstream or from the waiting SKID entry
    always_comb begin
        out_instr_in = out_from_skid ? skid_instr : i_instr;
        out_ctrl_in  = out_from_skid ? skid_ctrl  : i_ctrl;
        out_data_in  = out_from_skid ? skid_data  : i_data;
    end

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .NOP_INSTR(NOP_INSTR)
    ) u_out_slot (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_load (out_load),
        .i_instr(out_instr_in),
        .i_ctrl (out_ctrl_in),
        .i_data (out_data_in),
        .o_instr(out_instr),
        .o_ctrl (out_ctrl),
        .o_data (out_data)
    );

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .NOP_INSTR(NOP_INSTR)
    ) u_skid_slot (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_load (skid_load),
        .i_instr(i_instr),
        .i_ctrl (i_ctrl),
        .i_data (i_data),
        .o_instr(skid_instr),
        .o_ctrl (skid_ctrl),
        .o_data (skid_data)
    );

    // Bubbles present a no-op with cleared control; payload keeps its last value
    always_comb begin
        o_valid = (state_reg != EMPTY);
        o_instr = o_valid ? out_instr : NOP_INSTR;
        o_ctrl  = o_valid ? out_ctrl : '0;
        o_data  = out_data;
        o_ready = ready_reg;
        o_count = state_count(state_reg);
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed sequences with explicit expected values,
// plus a scoreboard fed on every accept and drained by a monitor on every
// downstream handshake, which also checks bubbles and stall stability.
module tb_pipe_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_rst_n, i_flush, i_valid, i_ready;
    logic [31:0] i_instr, i_data;
    logic [7:0]  i_ctrl;
    logic        o_ready, o_valid;
    logic [31:0] o_instr, o_data;
    logic [7:0]  o_ctrl;
    logic [1:0]  o_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [71:0] sb[$];
    logic        stall_pending = 1'b0;
    logic [71:0] stall_snap;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .i_clk  (clk),
        .i_rst_n(i_rst_n),
        .i_flush(i_flush),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_instr(i_instr),
        .i_ctrl (i_ctrl),
        .i_data (i_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_instr(o_instr),
        .o_ctrl (o_ctrl),
        .o_data (o_data),
        .o_count(o_count)
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [7:0] c, input logic [31:0] d);
        i_valid = v;
        i_instr = ins;
        i_ctrl  = c;
        i_data  = d;
    endtask

    // Scoreboard: push on accept, pop and compare on drain, check bubbles and stalls
    always @(negedge clk) begin
        if (!i_rst_n) begin
            stall_pending = 1'b0;
        end else begin
            if (i_valid && o_ready && !i_flush)
                sb.push_back({i_instr, i_ctrl, i_data});
            if (o_valid) begin
                if (stall_pending)
                    check("stall_stable", {o_instr, o_ctrl, o_data}, stall_snap);
                if (i_ready) begin
                    stall_pending = 1'b0;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_underflow: got %h expected no entry at %0t",
                                 {o_instr, o_ctrl, o_data}, $time);
                    end else begin
                        check("sb_order", {o_instr, o_ctrl, o_data}, sb.pop_front());
                    end
                end else begin
                    stall_pending = 1'b1;
                    stall_snap    = {o_instr, o_ctrl, o_data};
                end
            end else begin
                stall_pending = 1'b0;
                check("bubble_instr", {40'd0, o_instr}, {40'd0, NOP});
                check("bubble_ctrl", {64'd0, o_ctrl}, 72'd0);
            end
        end
    end

    initial begin
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        drive(1'b0, 32'd0, 8'd0, 32'd0);

        // Reset state, before any clock edge
        #3;
        check("rst_valid", {71'd0, o_valid}, 72'd0);
        check("rst_ready", {71'd0, o_ready}, 72'd0);
        check("rst_instr", {40'd0, o_instr}, {40'd0, NOP});
        check("rst_ctrl", {64'd0, o_ctrl}, 72'd0);
        check("rst_data", {40'd0, o_data}, 72'd0);
        check("rst_count", {70'd0, o_count}, 72'd0);

        @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        check("ready_before_edge", {71'd0, o_ready}, 72'd0);
        step();
        check("ready_after_rst", {71'd0, o_ready}, 72'd1);

        // First entry: visible one edge after acceptance
        i_ready = 1'b1;
        drive(1'b1, 32'h00A0_0093, 8'h5A, 32'h0000_1111);
        step();
        drive(1'b0, 32'd0, 8'd0, 32'd0);
        check("first_valid", {71'd0, o_valid}, 72'd1);
        check("first_instr", {40'd0, o_instr}, {40'd0, 32'h00A0_0093});
        check("first_count", {70'd0, o_count}, 72'd1);
        step();
        check("first_drained", {70'd0, o_count}, 72'd0);

        // Stream of 8 at full throughput
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h0000_1000 + k, 8'(k), 32'hD000_0000 + k);
            step();
            check("stream_valid", {71'd0, o_valid}, 72'd1);
            check("stream_instr", {40'd0, o_instr}, {40'd0, 32'h0000_1000 + k});
            check("stream_ready", {71'd0, o_ready}, 72'd1);
        end
        drive(1'b0, 32'd0, 8'd0, 32'd0);
        step();
        check("stream_end", {71'd0, o_valid}, 72'd0);
        check("bubble_data_hold", {40'd0, o_data}, {40'd0, 32'hD000_0007});

        // Fill under stall, then release
        i_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0001, 8'h11, 32'h0000_00A1);
        step();
        drive(1'b1, 32'hBBBB_0002, 8'h22, 32'h0000_00B2);
        step();
        drive(1'b0, 32'd0, 8'd0, 32'd0);
        check("full_count", {70'd0, o_count}, 72'd2);
        check("full_ready", {71'd0, o_ready}, 72'd0);
        check("full_instr", {40'd0, o_instr}, {40'd0, 32'hAAAA_0001});
        step();
        check("full_hold", {40'd0, o_instr}, {40'd0, 32'hAAAA_0001});
        i_ready = 1'b1;
        step();
        check("drain_second", {40'd0, o_instr}, {40'd0, 32'hBBBB_0002});
        check("drain_count", {70'd0, o_count}, 72'd1);
        check("drain_ready", {71'd0, o_ready}, 72'd1);
        step();
        check("drain_empty", {71'd0, o_valid}, 72'd0);

        // Flush while full, with a competing valid
        i_ready = 1'b0;
        drive(1'b1, 32'hC000_0001, 8'h33, 32'h0000_00C1);
        step();
        drive(1'b1, 32'hC000_0002, 8'h44, 32'h0000_00C2);
        step();
        i_flush = 1'b1;
        drive(1'b1, 32'hC000_0003, 8'h55, 32'h0000_00C3);
        step();
        sb.delete();
        i_flush = 1'b0;
        drive(1'b0, 32'd0, 8'd0, 32'd0);
        check("flush_valid", {71'd0, o_valid}, 72'd0);
        check("flush_instr", {40'd0, o_instr}, {40'd0, NOP});
        check("flush_ctrl", {64'd0, o_ctrl}, 72'd0);
        check("flush_count", {70'd0, o_count}, 72'd0);
        check("flush_ready", {71'd0, o_ready}, 72'd1);

        // Asynchronous reset while full
        drive(1'b1, 32'hE000_0001, 8'h66, 32'h0000_00E1);
        step();
        drive(1'b1, 32'hE000_0002, 8'h77, 32'h0000_00E2);
        step();
        drive(1'b0, 32'd0, 8'd0, 32'd0);
        check("pre_rst_count", {70'd0, o_count}, 72'd2);
        #1;
        i_rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_valid", {71'd0, o_valid}, 72'd0);
        check("arst_ready", {71'd0, o_ready}, 72'd0);
        check("arst_data", {40'd0, o_data}, 72'd0);
        check("arst_count", {70'd0, o_count}, 72'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        step();
        check("arst_ready_back", {71'd0, o_ready}, 72'd1);
        check("arst_still_empty", {71'd0, o_valid}, 72'd0);

        // Random handshakes; the monitor checks order, loss and stall stability
        for (int c = 0; c < 10000; c++) begin
            i_ready = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 1)), $urandom, 8'($urandom), $urandom);
            step();
        end
        drive(1'b0, 32'd0, 8'd0, 32'd0);
        i_ready = 1'b1;
        for (int w = 0; w < 20 && sb.size() != 0; w++) step();
        check("sb_empty_at_end", 72'(sb.size()), 72'd0);
        step();
        check("final_count", {70'd0, o_count}, 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
